// File: rtl/toggle_period_meter.sv
// Measures i_Clk cycles between successive level changes of an asynchronous input,
// with stall timeout. Define RATE_CLASSIFY_EN to add the o_Rate classification output.
module toggle_period_meter #(
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 16000000
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Sig,
  output logic [CNT_W-1:0] o_Period,
  output logic             o_Valid,
  output logic             o_Timeout
`ifdef RATE_CLASSIFY_EN
  ,
  output logic [2:0]       o_Rate
`endif
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    DISARMED = 1'b0,
    ARMED    = 1'b1
  } state_t;

  state_t           r_State;
  logic             r_S1;
  logic             r_S2;
  logic             r_S3;
  logic [CNT_W-1:0] r_Count;
  logic             w_Edge;
  logic [CNT_W-1:0] w_CntInc;

  assign w_Edge   = r_S2 ^ r_S3;
  assign w_CntInc = r_Count + CNT_W'(1);

`ifdef RATE_CLASSIFY_EN
  logic [31:0] w_PExt;
  logic [2:0]  w_RateCode;

  function automatic logic inBand(input logic [31:0] p, input logic [31:0] nom);
    return (p >= (nom - (nom >> 6))) && (p <= (nom + (nom >> 6)));
  endfunction

  assign w_PExt = 32'(w_CntInc);

  // Bands are disjoint, so priority order does not change the result.
  always_comb begin
    w_RateCode = 3'd0;
    if (inBand(w_PExt, 32'd12500000))     w_RateCode = 3'd1;
    else if (inBand(w_PExt, 32'd6250000)) w_RateCode = 3'd2;
    else if (inBand(w_PExt, 32'd3125000)) w_RateCode = 3'd3;
    else if (inBand(w_PExt, 32'd2500000)) w_RateCode = 3'd4;
  end
`endif

  // An edge always restarts the interval, even when it coincides with the timeout.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_S1      <= 1'b0;
      r_S2      <= 1'b0;
      r_S3      <= 1'b0;
      r_Count   <= '0;
      r_State   <= DISARMED;
      o_Period  <= '0;
      o_Valid   <= 1'b0;
      o_Timeout <= 1'b0;
`ifdef RATE_CLASSIFY_EN
      o_Rate    <= 3'd0;
`endif
    end else begin
      r_S1    <= i_Sig;
      r_S2    <= r_S1;
      r_S3    <= r_S2;
      o_Valid <= 1'b0;
      if (w_Edge) begin
        r_Count <= '0;
        if (r_State == ARMED) begin
          o_Period <= w_CntInc;
          o_Valid  <= 1'b1;
`ifdef RATE_CLASSIFY_EN
          o_Rate   <= w_RateCode;
`endif
        end else begin
          r_State   <= ARMED;
          o_Timeout <= 1'b0;
        end
      end else if (r_Count == LP_CNT_MAX) begin
        if (r_State == ARMED) begin
          r_State   <= DISARMED;
          o_Timeout <= 1'b1;
        end
      end else begin
        r_Count <= w_CntInc;
      end
    end
  end

endmodule

// File: tb/tb_toggle_period_meter.sv
// Scoreboard bench for toggle_period_meter: stimulus pushes expected events
// (measurement, timeout rise/fall) with their cycle; a negedge monitor pops and compares.
module tb_toggle_period_meter;

  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 32;

  logic             i_Clk = 1'b0;
  logic             i_Rst_L;
  logic             i_Sig;
  logic [CNT_W-1:0] o_Period;
  logic             o_Valid;
  logic             o_Timeout;
`ifdef RATE_CLASSIFY_EN
  logic [2:0]       o_Rate;
`endif

  typedef struct {
    int cyc;
    int kind;
    int val;
  } event_t;

  event_t expQ[$];
  int     checkCount    = 0;
  int     errorCount    = 0;
  int     cyc           = 0;
  logic   rstSampled    = 1'b0;
  logic   prevTimeout   = 1'b0;
  bit     modelArmed    = 1'b0;
  bit     modelTimedOut = 1'b0;
  int     lastToggle    = 0;

  toggle_period_meter #(
    .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_Sig(i_Sig),
    .o_Period(o_Period),
    .o_Valid(o_Valid),
    .o_Timeout(o_Timeout)
`ifdef RATE_CLASSIFY_EN
    ,
    .o_Rate(o_Rate)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  always @(posedge i_Clk) begin
    cyc        = cyc + 1;
    rstSampled = i_Rst_L;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

`ifdef RATE_CLASSIFY_EN
  function automatic int rateOf(input int p);
    int noms[4] = '{12500000, 6250000, 3125000, 2500000};
    for (int i = 0; i < 4; i++) begin
      if (p >= noms[i] - (noms[i] >> 6) && p <= noms[i] + (noms[i] >> 6)) return i + 1;
    end
    return 0;
  endfunction
`endif

  task automatic pushEvent(input int evCyc, input int kind, input int val);
    event_t e;
    e.cyc  = evCyc;
    e.kind = kind;
    e.val  = val;
    expQ.push_back(e);
  endtask

  // kind 0 = measurement, 1 = timeout rise, 2 = timeout fall
  task automatic checkEvent(input int kind, input int val);
    event_t e;
    if (expQ.size() == 0) begin
      checkOutput("unexpected_event", kind, -1);
    end else begin
      e = expQ.pop_front();
      checkOutput("event_kind", kind, e.kind);
      checkOutput("event_cycle", cyc, e.cyc);
      if (kind == 0 && e.kind == 0) begin
        checkOutput("period", val, e.val);
`ifdef RATE_CLASSIFY_EN
        checkOutput("rate", int'(o_Rate), rateOf(e.val));
`endif
      end
    end
  endtask

  always @(negedge i_Clk) begin
    if (!rstSampled) begin
      checkOutput("rst_valid", int'(o_Valid), 0);
      checkOutput("rst_period", int'(o_Period), 0);
      checkOutput("rst_timeout", int'(o_Timeout), 0);
      prevTimeout = 1'b0;
    end else begin
      if (o_Valid === 1'b1) checkEvent(0, int'(o_Period));
      if (o_Timeout !== prevTimeout) checkEvent((o_Timeout === 1'b1) ? 1 : 2, 0);
      prevTimeout = o_Timeout;
    end
  end

  task automatic pushTimeoutIfDue(input int untilCyc);
    if (modelArmed && (lastToggle + 3 + TIMEOUT <= untilCyc)) begin
      pushEvent(lastToggle + 3 + TIMEOUT, 1, 0);
      modelArmed    = 1'b0;
      modelTimedOut = 1'b1;
    end
  endtask

  task automatic applyStimulus(input int gap);
    int c;
    c = cyc + gap;
    pushTimeoutIfDue(c + 2);
    repeat (gap) @(posedge i_Clk);
    #1;
    i_Sig = ~i_Sig;
    if (modelArmed) begin
      pushEvent(c + 3, 0, c - lastToggle);
    end else begin
      if (modelTimedOut) pushEvent(c + 3, 2, 0);
      modelTimedOut = 1'b0;
      modelArmed    = 1'b1;
    end
    lastToggle = c;
  endtask

  task automatic idle(input int n);
    pushTimeoutIfDue(cyc + n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  // A high input at release looks like a fresh edge to the synchronizer and only arms.
  task automatic resetPulse(input int n, input bit wiggle);
    i_Rst_L = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge i_Clk);
      #1;
      if (wiggle && (i % 2 == 1)) i_Sig = ~i_Sig;
    end
    i_Rst_L       = 1'b1;
    modelArmed    = 1'b0;
    modelTimedOut = 1'b0;
    if (i_Sig) begin
      modelArmed = 1'b1;
      lastToggle = cyc;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_Sig   = 1'b0;
    i_Rst_L = 1'b0;
    resetPulse(5, 1'b1);
    idle(3);

    repeat (6) applyStimulus(10);
    repeat (3) applyStimulus(7);
    applyStimulus(1);

    applyStimulus(TIMEOUT - 1);
    applyStimulus(TIMEOUT);
    idle(TIMEOUT + 13);
    applyStimulus(10);
    applyStimulus(10);
    applyStimulus(10);

    if (i_Sig) applyStimulus(10);
    idle(4);
    resetPulse(1, 1'b0);
    applyStimulus(10);
    applyStimulus(10);
    applyStimulus(10);

    repeat (20) applyStimulus(int'($urandom_range(1, 40)));
    idle(TIMEOUT + 10);
    idle(2);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
